// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one full-subtractor step per clock.
// A start/done handshake frames each operation; results hold until the next completion.

module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q, overflow_d;

  logic cell_d;
  logic cell_bout;
  logic last_bit;

  full_sub_cell u_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (state_q == SHIFT) && (count_q == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_sh_d     = res_sh_q;
    borrow_d     = borrow_q;
    count_d      = count_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          res_sh_d = '0;
          borrow_d = 1'b0;
          count_d  = '0;
          busy_d   = 1'b1;
        end
      end
      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {cell_d, res_sh_q[WIDTH-1:1]};
        borrow_d = cell_bout;
        count_d  = count_q + CW'(1);
        // On the last bit the shifters' LSBs are the captured operand MSBs.
        if (last_bit) begin
          diff_d       = {cell_d, res_sh_q[WIDTH-1:1]};
          borrow_out_d = cell_bout;
          overflow_d   = (a_sh_q[0] != b_sh_q[0]) && (cell_d != a_sh_q[0]);
          done_d       = 1'b1;
          busy_d       = 1'b0;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_sh_q     <= '0;
      borrow_q     <= 1'b0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_sh_q     <= res_sh_d;
      borrow_q     <= borrow_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH = 8) with hand-computed results.
// Inputs are driven and outputs sampled 1 ns after each rising edge.

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  int tests_run;
  int tests_failed;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pulses start for one accept edge with the given operands.
  task automatic applyStimulus(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v);
    a     = a_v;
    b     = b_v;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles after the accept edge until done, bounded.
  task automatic waitDone(input string tag, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 3 * WIDTH) begin
      if (busy !== 1'b1) begin
        checkOutput({tag, "_busy_during"}, 32'(busy), 32'd1);
      end
      tick();
      cycles++;
    end
    checkOutput({tag, "_latency"}, cycles, WIDTH);
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                       input logic [WIDTH-1:0] exp_diff, input logic exp_bo, input logic exp_ov);
    int cycles;
    applyStimulus(a_v, b_v);
    checkOutput({tag, "_busy_start"}, 32'(busy), 32'd1);
    waitDone(tag, cycles);
    checkOutput({tag, "_diff"}, 32'(diff), 32'(exp_diff));
    checkOutput({tag, "_borrow"}, 32'(borrow_out), 32'(exp_bo));
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'(exp_ov));
    checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
    tick();
    checkOutput({tag, "_done_clear"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cycles;
    int done_seen;
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_diff", 32'(diff), 32'd0);
    checkOutput("rst_borrow", 32'(borrow_out), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);

    runOp("sub_10_3", 8'd10, 8'd3, 8'h07, 1'b0, 1'b0);
    runOp("sub_3_10", 8'd3, 8'd10, 8'hF9, 1'b1, 1'b0);
    runOp("sub_0_0", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    runOp("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    runOp("sub_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Abort 9-4 mid-operation; previous result (0x80, borrow 1, ovf 1) must be cleared.
    applyStimulus(8'd9, 8'd4);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_diff", 32'(diff), 32'd0);
    checkOutput("abort_borrow", 32'(borrow_out), 32'd0);
    checkOutput("abort_ovf", 32'(overflow), 32'd0);
    done_seen = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);
    runOp("sub_9_4", 8'd9, 8'd4, 8'h05, 1'b0, 1'b0);

    // start pulses and operand changes while busy must be ignored.
    applyStimulus(8'd5, 8'd5);
    tick();
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 8'h3C;
    b     = 8'hA5;
    done_seen = 0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      if (done === 1'b1) begin
        done_seen++;
        checkOutput("busy_case_diff", 32'(diff), 32'h00);
      end
      tick();
    end
    checkOutput("busy_case_one_done", done_seen, 1);
    checkOutput("busy_case_idle", 32'(busy), 32'd0);

    // Back-to-back: second start lands in the first done cycle.
    applyStimulus(8'd20, 8'd7);
    waitDone("b2b_first", cycles);
    checkOutput("b2b_first_diff", 32'(diff), 32'h0D);
    checkOutput("b2b_first_borrow", 32'(borrow_out), 32'd0);
    a     = 8'd7;
    b     = 8'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("b2b_done_drop", 32'(done), 32'd0);
    checkOutput("b2b_busy_rise", 32'(busy), 32'd1);
    cycles = 1;
    while (done !== 1'b1 && cycles < 3 * WIDTH) begin
      if (diff !== 8'h0D) checkOutput("b2b_hold_diff", 32'(diff), 32'h0D);
      tick();
      cycles++;
    end
    checkOutput("b2b_gap", cycles, WIDTH + 1);
    checkOutput("b2b_second_diff", 32'(diff), 32'hF3);
    checkOutput("b2b_second_borrow", 32'(borrow_out), 32'd1);
    checkOutput("b2b_second_ovf", 32'(overflow), 32'd0);
    tick();
    checkOutput("b2b_done_clear", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
